map_window_gen: RTL and testbench

//  Pipelined, parametrised 4x4 activation-window extractor feeding the conv PE array.

---
 rtl/map_window_gen_if.sv | 35 +++
 rtl/map_window_gen.sv | 76 +++++++
 tb/tb_map_window_gen.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/map_window_gen_if.sv
// map_window_gen_if: upstream beat, SRAM read words and downstream window bundle.
interface map_window_gen_if #(
  parameter int CH_NUM     = 24,
  parameter int BW_PER_ACT = 16,
  parameter int CH_BW      = 5,
  parameter int CNT_BW     = 16
);
  localparam int WORD_BW = CH_NUM * 4 * BW_PER_ACT;
  logic                    in_valid;
  logic                    in_ready;
  logic                    bank_sel;
  logic [1:0]              map_type;
  logic [CH_BW-1:0]        ch_idx;
  logic [3:0]              pad_mask;
  logic [WORD_BW-1:0]      rdata_a0, rdata_a1, rdata_a2, rdata_a3;
  logic [WORD_BW-1:0]      rdata_b0, rdata_b1, rdata_b2, rdata_b3;
  logic                    out_valid;
  logic                    out_ready;
  logic [16*BW_PER_ACT-1:0] out_map;
  logic [CNT_BW-1:0]       map_cnt;
  modport master (
    output in_valid, bank_sel, map_type, ch_idx, pad_mask,
    output rdata_a0, rdata_a1, rdata_a2, rdata_a3,
    output rdata_b0, rdata_b1, rdata_b2, rdata_b3,
    output out_ready,
    input  in_ready, out_valid, out_map, map_cnt
  );
  modport slave (
    input  in_valid, bank_sel, map_type, ch_idx, pad_mask,
    input  rdata_a0, rdata_a1, rdata_a2, rdata_a3,
    input  rdata_b0, rdata_b1, rdata_b2, rdata_b3,
    input  out_ready,
    output in_ready, out_valid, out_map, map_cnt
  );
endinterface

// File: rtl/map_window_gen.sv
// map_window_gen: 2-stage 4x4 activation-window extractor with un-rotation and edge padding.
module map_window_gen #(
  parameter int CH_NUM     = 24,
  parameter int BW_PER_ACT = 16,
  parameter int CH_BW      = 5,
  parameter int CNT_BW     = 16
) (
  input logic clk,
  input logic rst_n,
  input logic clr,
  map_window_gen_if.slave bus
);
  localparam int PATCH_BW = 4 * BW_PER_ACT;
  localparam int WORD_BW  = CH_NUM * PATCH_BW;
  logic                              s1_valid;
  logic [1:0]                        s1_map_type;
  logic [3:0]                        s1_pad;
  logic [3:0][3:0][BW_PER_ACT-1:0]   s1_p;
  logic [3:0][3:0][BW_PER_ACT-1:0]   p_nxt;
  logic [15:0][BW_PER_ACT-1:0]       win;
  logic [WORD_BW-1:0]                words [4];
  logic                              out_valid;
  logic [16*BW_PER_ACT-1:0]          out_map;
  logic [CNT_BW-1:0]                 map_cnt;
  logic                              s2_rdy, in_ready, acc, ch_ok;
  assign s2_rdy   = !out_valid || bus.out_ready;
  assign in_ready = !clr && (!s1_valid || s2_rdy);
  assign acc      = bus.in_valid && in_ready;
  assign ch_ok    = int'(bus.ch_idx) < CH_NUM;
  assign words[0] = bus.bank_sel ? bus.rdata_b0 : bus.rdata_a0;
  assign words[1] = bus.bank_sel ? bus.rdata_b1 : bus.rdata_a1;
  assign words[2] = bus.bank_sel ? bus.rdata_b2 : bus.rdata_a2;
  assign words[3] = bus.bank_sel ? bus.rdata_b3 : bus.rdata_a3;
  // Channel 0 sits at the MSB end, so shifting right brings channel ch_idx to the bottom patch slot.
  for (genvar i = 0; i < 4; i++) begin : g_sub
    logic [WORD_BW-1:0] sh;
    assign sh = words[i] >> ((CH_NUM - 1 - int'(bus.ch_idx)) * PATCH_BW);
    for (genvar j = 0; j < 4; j++) begin : g_act
      assign p_nxt[i][j] = ch_ok ? sh[(3-j)*BW_PER_ACT +: BW_PER_ACT] : '0;
    end
  end
  // Quadrant q (TL,TR,BL,BR) comes from sub-bank map_type^q; padding masks whole rows/cols.
  always_comb begin
    win = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        win[4'(4*r+c)] = ((r == 0 && s1_pad[0]) || (r == 3 && s1_pad[1]) ||
                          (c == 0 && s1_pad[2]) || (c == 3 && s1_pad[3])) ? '0 :
                         s1_p[s1_map_type ^ 2'(2*(r/2) + c/2)][2'(2*(r%2) + c%2)];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_map_type <= '0;
      s1_pad      <= '0;
      s1_p        <= '0;
      out_valid   <= 1'b0;
      out_map     <= '0;
      map_cnt     <= '0;
    end else begin
      s1_valid <= clr ? 1'b0 : (in_ready ? bus.in_valid : s1_valid);
      if (acc) begin
        s1_p        <= p_nxt;
        s1_map_type <= bus.map_type;
        s1_pad      <= bus.pad_mask;
      end
      out_valid <= clr ? 1'b0 : (s2_rdy ? s1_valid : out_valid);
      if (!clr && s2_rdy && s1_valid) out_map <= win;
      map_cnt <= clr ? '0 : ((out_valid && bus.out_ready) ? map_cnt + 1'b1 : map_cnt);
    end
  end
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_map   = out_map;
  assign bus.map_cnt   = map_cnt;
endmodule

// File: tb/tb_map_window_gen.sv
// tb_map_window_gen: randomized and directed checks of map_window_gen against a behavioural window model.
module tb_map_window_gen;
  localparam int CH_NUM = 24, BW = 16, CH_BW = 5, CNT_BW = 16;
  localparam int PATCH = 4 * BW, WORD_BW = CH_NUM * PATCH;
  typedef logic [16*BW-1:0] map_t;
  logic clk = 1'b0, rst_n = 1'b1, clr = 1'b0;
  logic [WORD_BW-1:0] ra [4], rb [4];
  int total = 0, bad = 0;
  map_t exp_q [$];
  always #5 clk = ~clk;
  map_window_gen_if #(.CH_NUM(CH_NUM), .BW_PER_ACT(BW), .CH_BW(CH_BW), .CNT_BW(CNT_BW)) bus();
  map_window_gen #(.CH_NUM(CH_NUM), .BW_PER_ACT(BW), .CH_BW(CH_BW), .CNT_BW(CNT_BW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus));
  assign bus.rdata_a0 = ra[0];
  assign bus.rdata_a1 = ra[1];
  assign bus.rdata_a2 = ra[2];
  assign bus.rdata_a3 = ra[3];
  assign bus.rdata_b0 = rb[0];
  assign bus.rdata_b1 = rb[1];
  assign bus.rdata_b2 = rb[2];
  assign bus.rdata_b3 = rb[3];
  // Window as 4x4 grid: the 2x2 patch of quadrant q comes from the sub-bank listed for q.
  function automatic map_t model(input logic b, input logic [1:0] mt, input int ch, input logic [3:0] pad);
    logic [BW-1:0] p [4][4];
    logic [WORD_BW-1:0] w;
    int quad_sub [4];
    int top;
    map_t m = '0;
    quad_sub = '{int'(mt), int'(mt ^ 2'd1), int'(mt ^ 2'd2), int'(mt ^ 2'd3)};
    for (int i = 0; i < 4; i++) begin
      w = b ? rb[i] : ra[i];
      for (int j = 0; j < 4; j++) begin
        p[i][j] = '0;
        if (ch < CH_NUM) begin
          top = WORD_BW - ch * PATCH - j * BW;
          p[i][j] = w[top-1 -: BW];
        end
      end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!((r == 0 && pad[0]) || (r == 3 && pad[1]) || (c == 0 && pad[2]) || (c == 3 && pad[3])))
          m[(4*r+c)*BW +: BW] = p[quad_sub[2*(r/2) + c/2]][2*(r%2) + c%2];
    return m;
  endfunction
  function automatic map_t mk_map(input int v [16]);
    map_t m;
    for (int k = 0; k < 16; k++) m[k*BW +: BW] = BW'(v[k]);
    return m;
  endfunction
  function automatic logic [WORD_BW-1:0] rnd_word();
    logic [WORD_BW-1:0] w;
    for (int k = 0; k < WORD_BW / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction
  task automatic put_patch(input bit b, input int sub, input int ch, input int v0, input int v1, input int v2, input int v3);
    logic [WORD_BW-1:0] w;
    int top;
    top = WORD_BW - ch * PATCH;
    w = b ? rb[sub] : ra[sub];
    w[top-1 -: BW] = BW'(v0);
    w[top-1-BW -: BW] = BW'(v1);
    w[top-1-2*BW -: BW] = BW'(v2);
    w[top-1-3*BW -: BW] = BW'(v3);
    if (b) rb[sub] = w; else ra[sub] = w;
  endtask
  task automatic load_test1_data();
    for (int i = 0; i < 4; i++) begin
      ra[i] = rnd_word();
      rb[i] = rnd_word();
      put_patch(0, i, 0, 4*i+1, 4*i+2, 4*i+3, 4*i+4);
    end
  endtask
  task automatic rnd_fields();
    bus.bank_sel = 1'($urandom);
    bus.map_type = 2'($urandom);
    bus.ch_idx   = CH_BW'($urandom_range(0, CH_NUM));
    bus.pad_mask = 4'($urandom);
  endtask
  // Presents one beat for one cycle, then scrambles the sampled fields; returns #1 after the accept edge.
  task automatic send1(input logic b, input logic [1:0] mt, input int ch, input logic [3:0] pad);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.bank_sel = b; bus.map_type = mt;
    bus.ch_idx = CH_BW'(ch); bus.pad_mask = pad; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.bank_sel = ~b; bus.map_type = ~mt;
    bus.ch_idx = CH_BW'(CH_NUM - 1 - ch); bus.pad_mask = ~pad;
    #1;
  endtask
  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask
  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_map !== '0) begin bad++; $display("FAIL reset_out_map got=%h exp=0", bus.out_map); end
    total++; if (bus.map_cnt !== '0) begin bad++; $display("FAIL reset_map_cnt got=%0d exp=0", bus.map_cnt); end
    rst_n = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask
  task automatic test_basic();
    map_t exp1;
    exp1 = mk_map('{1,2,5,6, 3,4,7,8, 9,10,13,14, 11,12,15,16});
    load_test1_data();
    send1(0, 2'd0, 0, 4'b0000);
    for (int i = 0; i < 4; i++) ra[i] = ~ra[i];
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_latency1 out_valid got=%b exp=0", bus.out_valid); end
    @(negedge clk); #1;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL basic_latency2 out_valid got=%b exp=1", bus.out_valid); end
    total++; if (bus.out_map !== exp1) begin bad++; $display("FAIL basic_map got=%h exp=%h", bus.out_map, exp1); end
  endtask
  task automatic test_rotate();
    map_t e;
    load_test1_data();
    e = model(0, 2'd3, 0, 4'b0000);
    send1(0, 2'd3, 0, 4'b0000);
    @(negedge clk); #1;
    total++; if (bus.out_map[0 +: 4*BW] !== {16'd10, 16'd9, 16'd14, 16'd13}) begin bad++; $display("FAIL rot_row0 got=%h exp=000a0009000e000d", bus.out_map[0 +: 4*BW]); end
    total++; if (bus.out_map[12*BW +: 4*BW] !== {16'd4, 16'd3, 16'd8, 16'd7}) begin bad++; $display("FAIL rot_row3 got=%h exp=0004000300080007", bus.out_map[12*BW +: 4*BW]); end
    total++; if (bus.out_map !== e) begin bad++; $display("FAIL rot_map got=%h exp=%h", bus.out_map, e); end
    for (int i = 0; i < 4; i++) put_patch(1, i, 0, 4*i+101, 4*i+102, 4*i+103, 4*i+104);
    e = model(1, 2'd3, 0, 4'b0000);
    send1(1, 2'd3, 0, 4'b0000);
    @(negedge clk); #1;
    total++; if (bus.out_map[0 +: 4*BW] !== {16'd110, 16'd109, 16'd114, 16'd113}) begin bad++; $display("FAIL rot_b_row0 got=%h", bus.out_map[0 +: 4*BW]); end
    total++; if (bus.out_map !== e) begin bad++; $display("FAIL rot_b_map got=%h exp=%h", bus.out_map, e); end
  endtask
  task automatic test_pad();
    map_t e;
    load_test1_data();
    e = model(0, 2'd0, 0, 4'b0101);
    send1(0, 2'd0, 0, 4'b0101);
    @(negedge clk); #1;
    total++; if (bus.out_map !== e) begin bad++; $display("FAIL pad_map got=%h exp=%h", bus.out_map, e); end
    total++; if (bus.out_map[0 +: 4*BW] !== '0) begin bad++; $display("FAIL pad_row0 got=%h exp=0", bus.out_map[0 +: 4*BW]); end
    for (int r = 0; r < 4; r++) begin
      total++; if (bus.out_map[4*r*BW +: BW] !== '0) begin bad++; $display("FAIL pad_col0 row=%0d got=%h exp=0", r, bus.out_map[4*r*BW +: BW]); end
    end
    total++; if (bus.out_map[5*BW +: BW] !== 16'd4) begin bad++; $display("FAIL pad_e11 got=%0d exp=4", bus.out_map[5*BW +: BW]); end
    total++; if (bus.out_map[15*BW +: BW] !== 16'd16) begin bad++; $display("FAIL pad_e33 got=%0d exp=16", bus.out_map[15*BW +: BW]); end
  endtask
  task automatic test_channel();
    map_t e;
    logic [1:0] mt;
    for (int i = 0; i < 4; i++) begin ra[i] = rnd_word(); rb[i] = rnd_word(); end
    put_patch(0, 0, CH_NUM - 1, 16'h1234, 16'h5678, 16'h9abc, 16'hdef0);
    e = model(0, 2'd0, CH_NUM - 1, 4'b0000);
    send1(0, 2'd0, CH_NUM - 1, 4'b0000);
    @(negedge clk); #1;
    total++; if (bus.out_map !== e) begin bad++; $display("FAIL ch_last_map got=%h exp=%h", bus.out_map, e); end
    total++; if (bus.out_map[0 +: BW] !== 16'h1234) begin bad++; $display("FAIL ch_last_e00 got=%h exp=1234", bus.out_map[0 +: BW]); end
    mt = 2'($urandom);
    e = model(1, mt, CH_NUM / 2, 4'b0000);
    send1(1, mt, CH_NUM / 2, 4'b0000);
    @(negedge clk); #1;
    total++; if (bus.out_map !== e) begin bad++; $display("FAIL ch_mid_map got=%h exp=%h", bus.out_map, e); end
    send1(0, 2'd0, CH_NUM, 4'b0000);
    @(negedge clk); #1;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL ch_oob_valid got=%b exp=1", bus.out_valid); end
    total++; if (bus.out_map !== '0) begin bad++; $display("FAIL ch_oob_map got=%h exp=0", bus.out_map); end
  endtask
  task automatic test_back_to_back();
    int sent = 0, got = 0, cyc = 0;
    bit saw_block = 0;
    do_clr();
    exp_q.delete();
    while ((sent < 8 || got < 8) && cyc < 100) begin
      @(negedge clk);
      bus.in_valid = sent < 8;
      rnd_fields();
      for (int i = 0; i < 4; i++) begin ra[i] = rnd_word(); rb[i] = rnd_word(); end
      bus.out_ready = !(cyc >= 3 && cyc <= 6);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_extra_out got=%h", bus.out_map); end
        else begin
          if (bus.out_map !== exp_q[0]) begin bad++; $display("FAIL b2b_order idx=%0d got=%h exp=%h", got, bus.out_map, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        got++;
      end
      if (bus.in_valid && !bus.in_ready) begin
        saw_block = 1;
        total++; if (sent - got != 2) begin bad++; $display("FAIL b2b_buffered got=%0d exp=2", sent - got); end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.bank_sel, bus.map_type, int'(bus.ch_idx), bus.pad_mask));
        sent++;
      end
      if (cyc == 2) begin
        total++; if (sent != 3) begin bad++; $display("FAIL b2b_rate sent=%0d exp=3", sent); end
      end
      cyc++;
    end
    total++; if (!saw_block) begin bad++; $display("FAIL b2b_in_ready_drop got=never exp=seen"); end
    total++; if (got != 8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", got); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    total++; if (bus.map_cnt !== CNT_BW'(8)) begin bad++; $display("FAIL b2b_map_cnt got=%0d exp=8", bus.map_cnt); end
  endtask
  task automatic test_random();
    int got = 0, cyc = 0;
    do_clr();
    exp_q.delete();
    while ((cyc < 300 || exp_q.size() != 0) && cyc < 400) begin
      @(negedge clk);
      bus.in_valid = (cyc < 300) && ($urandom_range(0, 9) < 7);
      rnd_fields();
      for (int i = 0; i < 4; i++) begin ra[i] = rnd_word(); rb[i] = rnd_word(); end
      bus.out_ready = (cyc >= 300) || ($urandom_range(0, 9) < 6);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rnd_extra_out got=%h", bus.out_map); end
        else begin
          if (bus.out_map !== exp_q[0]) begin bad++; $display("FAIL rnd_map idx=%0d got=%h exp=%h", got, bus.out_map, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.bank_sel, bus.map_type, int'(bus.ch_idx), bus.pad_mask));
      cyc++;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_drain left=%0d exp=0", exp_q.size()); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    total++; if (bus.map_cnt !== CNT_BW'(got)) begin bad++; $display("FAIL rnd_map_cnt got=%0d exp=%0d", bus.map_cnt, got); end
  endtask
  task automatic test_clr();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.out_ready = 1'b0; rnd_fields();
    @(negedge clk);
    rnd_fields();
    @(negedge clk);
    clr = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL clr_in_ready got=%b exp=0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL clr_prefill out_valid got=%b exp=1", bus.out_valid); end
    @(negedge clk);
    clr = 1'b0; bus.in_valid = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL clr_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.map_cnt !== '0) begin bad++; $display("FAIL clr_map_cnt got=%0d exp=0", bus.map_cnt); end
    repeat (3) @(negedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL clr_flushed out_valid got=%b exp=0", bus.out_valid); end
  endtask
  task automatic test_async_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.out_ready = 1'b1; rnd_fields();
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    #1;
    total++; if (bus.map_cnt !== CNT_BW'(3)) begin bad++; $display("FAIL arst_pre_cnt got=%0d exp=3", bus.map_cnt); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL arst_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.out_map !== '0) begin bad++; $display("FAIL arst_out_map got=%h exp=0", bus.out_map); end
    total++; if (bus.map_cnt !== '0) begin bad++; $display("FAIL arst_map_cnt got=%0d exp=0", bus.map_cnt); end
    @(negedge clk);
    rst_n = 1'b1; bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL arst_lost_beats out_valid got=%b exp=0", bus.out_valid); end
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.bank_sel = 1'b0;
    bus.map_type = '0; bus.ch_idx = '0; bus.pad_mask = '0;
    for (int i = 0; i < 4; i++) begin ra[i] = '0; rb[i] = '0; end
    test_reset();
    test_basic();
    test_rotate();
    test_pad();
    test_channel();
    test_back_to_back();
    test_random();
    test_clr();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
